// File: rtl/ifft_butterfly_dit.sv
// Radix-2 DIT butterfly: Ya = xa + xb*W', Yb = xa - xb*W'.
// W' is W or conj(W) per sample; optional 1/2 output scaling per sample.
// Three register stages (operands, product, output) share one advance
// enable, so a stalled output freezes the whole pipeline.
module ifft_butterfly_dit #(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    conj,
   input  logic                    scale,
   input  logic signed [WIDTH-1:0] xa_re,
   input  logic signed [WIDTH-1:0] xa_im,
   input  logic signed [WIDTH-1:0] xb_re,
   input  logic signed [WIDTH-1:0] xb_im,
   input  logic signed [WIDTH-1:0] W_re,
   input  logic signed [WIDTH-1:0] W_im,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] Ya_re,
   output logic signed [WIDTH-1:0] Ya_im,
   output logic signed [WIDTH-1:0] Yb_re,
   output logic signed [WIDTH-1:0] Yb_im,
   output logic                    ovf,
   input  logic                    clr_ovf
);

   localparam int PW = 2*WIDTH + 1;   // full complex-product width
   localparam int SW = WIDTH + 2;     // sum width with headroom for the +1 rounding term
   localparam logic signed [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] NEG_MAX  = -POS_MAX;
   localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   // Product scaled back to Q1.(WIDTH-1) (floor), then symmetric saturation.
   // Returns {saturated, value}.
   function automatic logic [WIDTH:0] sat_product(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] t;
      t = p >>> (WIDTH-1);
      if (t > PW'(POS_MAX))      return {1'b1, POS_MAX};
      else if (t < PW'(NEG_MAX)) return {1'b1, NEG_MAX};
      else                       return {1'b0, t[WIDTH-1:0]};
   endfunction

   // Output lane: halve with round-half-up (cannot overflow) or saturate
   // symmetrically so the most negative code is never produced.
   function automatic logic [WIDTH:0] finish_sum(input logic signed [SW-1:0] s,
                                                 input logic halve);
      if (halve)                 return {1'b0, WIDTH'((s + SW'(1)) >>> 1)};
      else if (s > SW'(POS_MAX)) return {1'b1, POS_MAX};
      else if (s < SW'(NEG_MAX)) return {1'b1, NEG_MAX};
      else                       return {1'b0, s[WIDTH-1:0]};
   endfunction

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Stage registers
   logic                    s1_valid, s2_valid, s1_scale, s2_scale;
   logic signed [WIDTH-1:0] s1_xa_re, s1_xa_im, s1_xb_re, s1_xb_im, s1_w_re, s1_wi;
   logic signed [WIDTH-1:0] s2_xa_re, s2_xa_im, s2_t_re, s2_t_im;

   // Twiddle imaginary part, conjugated when requested (negating the most
   // negative code clips to POS_MAX and is not an overflow event).
   logic signed [WIDTH-1:0] wi_next;
   always_comb begin
      // NOTE: default first so every path assigns wi_next -- no latch.
      wi_next = W_im;
      if (conj) wi_next = (W_im == MOST_NEG) ? POS_MAX : -W_im;
   end

   // Complex product xb * W' at full precision
   logic signed [PW-1:0] p_re, p_im;
   logic [WIDTH:0] t_re_n, t_im_n;
   assign p_re   = PW'(s1_xb_re) * PW'(s1_w_re) - PW'(s1_xb_im) * PW'(s1_wi);
   assign p_im   = PW'(s1_xb_re) * PW'(s1_wi)   + PW'(s1_xb_im) * PW'(s1_w_re);
   assign t_re_n = sat_product(p_re);
   assign t_im_n = sat_product(p_im);

   // Butterfly sums and output formatting
   logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
   logic [WIDTH:0] ya_re_n, ya_im_n, yb_re_n, yb_im_n;
   assign sum_re  = SW'(s2_xa_re) + SW'(s2_t_re);
   assign sum_im  = SW'(s2_xa_im) + SW'(s2_t_im);
   assign dif_re  = SW'(s2_xa_re) - SW'(s2_t_re);
   assign dif_im  = SW'(s2_xa_im) - SW'(s2_t_im);
   assign ya_re_n = finish_sum(sum_re, s2_scale);
   assign ya_im_n = finish_sum(sum_im, s2_scale);
   assign yb_re_n = finish_sum(dif_re, s2_scale);
   assign yb_im_n = finish_sum(dif_im, s2_scale);

   // Saturation events only count for real samples, never bubbles
   logic sat_s2, sat_s3;
   assign sat_s2 = s1_valid && (t_re_n[WIDTH] || t_im_n[WIDTH]);
   assign sat_s3 = s2_valid && (ya_re_n[WIDTH] || ya_im_n[WIDTH] ||
                                yb_re_n[WIDTH] || yb_im_n[WIDTH]);

   // Control path: stage valids, outputs and sticky ovf; all frozen on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         Ya_re     <= '0;
         Ya_im     <= '0;
         Yb_re     <= '0;
         Yb_im     <= '0;
         ovf       <= 1'b0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid) begin
            Ya_re <= ya_re_n[WIDTH-1:0];
            Ya_im <= ya_im_n[WIDTH-1:0];
            Yb_re <= yb_re_n[WIDTH-1:0];
            Yb_im <= yb_im_n[WIDTH-1:0];
         end
         ovf <= (ovf && !clr_ovf) || sat_s2 || sat_s3;
      end
   end

   // Data path: operands and partial results move with the pipeline.
   // NOTE: no reset here -- contents are ignored until the matching valid is set.
   always_ff @(posedge clk) begin
      if (adv) begin
         s1_xa_re <= xa_re;
         s1_xa_im <= xa_im;
         s1_xb_re <= xb_re;
         s1_xb_im <= xb_im;
         s1_w_re  <= W_re;
         s1_wi    <= wi_next;
         s1_scale <= scale;
         s2_xa_re <= s1_xa_re;
         s2_xa_im <= s1_xa_im;
         s2_t_re  <= t_re_n[WIDTH-1:0];
         s2_t_im  <= t_im_n[WIDTH-1:0];
         s2_scale <= s1_scale;
      end
   end

endmodule

// File: tb/tb_ifft_butterfly_dit.sv
// Self-checking bench for ifft_butterfly_dit: scoreboard fed by an
// integer-arithmetic reference model, plus directed reset, stall and
// saturation scenarios.
module tb_ifft_butterfly_dit;

   localparam int W    = 16;
   localparam int MAXV = 2**(W-1) - 1;
   localparam int ONE  = 2**(W-1);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                in_valid = 1'b1;
   logic                in_ready;
   logic                conj = 1'b0;
   logic                scale = 1'b0;
   logic signed [W-1:0] xa_re = '0, xa_im = '0, xb_re = '0, xb_im = '0;
   logic signed [W-1:0] W_re = '0, W_im = '0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic signed [W-1:0] Ya_re, Ya_im, Yb_re, Yb_im;
   logic                ovf;
   logic                clr_ovf = 1'b0;

   ifft_butterfly_dit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .conj(conj), .scale(scale),
      .xa_re(xa_re), .xa_im(xa_im), .xb_re(xb_re), .xb_im(xb_im),
      .W_re(W_re), .W_im(W_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .Ya_re(Ya_re), .Ya_im(Ya_im), .Yb_re(Yb_re), .Yb_im(Yb_im),
      .ovf(ovf), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ya_re;
      int ya_im;
      int yb_re;
      int yb_im;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // ---------------- reference model (plain integer arithmetic) ----------------
   function automatic int floor_div(input longint n, input longint d);
      longint q;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      return int'(q);
   endfunction

   function automatic int clamp(input int v);
      if (v > MAXV)  return MAXV;
      if (v < -MAXV) return -MAXV;
      return v;
   endfunction

   function automatic int finish(input int s, input bit sc);
      return sc ? floor_div(longint'(s) + 1, 2) : clamp(s);
   endfunction

   function automatic exp_t model(input int xar, input int xai, input int xbr,
                                  input int xbi, input int wr, input int wim,
                                  input bit cj, input bit sc);
      exp_t e;
      int   wi, tr, ti;
      wi = cj ? -wim : wim;
      if (wi > MAXV) wi = MAXV;
      tr = clamp(floor_div(longint'(xbr) * wr - longint'(xbi) * wi, ONE));
      ti = clamp(floor_div(longint'(xbr) * wi + longint'(xbi) * wr, ONE));
      e.ya_re = finish(xar + tr, sc);
      e.ya_im = finish(xai + ti, sc);
      e.yb_re = finish(xar - tr, sc);
      e.yb_im = finish(xai - ti, sc);
      return e;
   endfunction

   // Input observer: every accepted sample pushes its expected result; reset
   // discards everything in flight.
   always @(negedge clk) begin
      if (rst) sb.delete();
      else if (in_valid && in_ready)
         sb.push_back(model(int'(xa_re), int'(xa_im), int'(xb_re), int'(xb_im),
                            int'(W_re), int'(W_im), conj, scale));
   end

   // Output monitor: every transferred result is compared with the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && out_valid === 1'b1 && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: output Ya=(%0d,%0d) with empty scoreboard",
                     Ya_re, Ya_im);
         end else begin
            e = sb.pop_front();
            check("sb_Ya_re", Ya_re, e.ya_re);
            check("sb_Ya_im", Ya_im, e.ya_im);
            check("sb_Yb_re", Yb_re, e.yb_re);
            check("sb_Yb_im", Yb_im, e.yb_im);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one sample and hold it until accepted (bounded).
   task automatic send(input int xar, input int xai, input int xbr, input int xbi,
                       input int wr, input int wim, input bit cj, input bit sc);
      int guard;
      bit acc;
      xa_re = xar[W-1:0]; xa_im = xai[W-1:0];
      xb_re = xbr[W-1:0]; xb_im = xbi[W-1:0];
      W_re  = wr[W-1:0];  W_im  = wim[W-1:0];
      conj  = cj;         scale = sc;
      in_valid = 1'b1;
      guard = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!acc && guard < 200);
      if (!acc) check("accept_timeout", {31'b0, acc}, 1);
      in_valid = 1'b0;
   endtask

   // Count negedges until out_valid appears (bounded); ends on that negedge.
   task automatic wait_out(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (out_valid !== 1'b1 && n < 50);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 200) begin
         cycles(1);
         g++;
      end
      check("drain_empty", sb.size(), 0);
      cycles(2);
   endtask

   function automatic int rnd();
      int sel;
      sel = int'($urandom_range(9));
      case (sel)
         0:       return -ONE;
         1:       return -MAXV;
         2:       return MAXV;
         default: return int'($urandom_range(65535)) - ONE;
      endcase
   endfunction

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   bit  rnd_done = 1'b0;
   int  lat;
   logic signed [W-1:0] hold_a_re, hold_a_im, hold_b_re, hold_b_im;

   initial begin
      // T1: reset held two cycles with in_valid asserted
      cycles(2);
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_Ya_re", Ya_re, 0);
      check("rst_Ya_im", Ya_im, 0);
      check("rst_Yb_re", Yb_re, 0);
      check("rst_Yb_im", Yb_im, 0);
      check("rst_ovf", ovf, 0);
      check("rst_in_ready", in_ready, 1);
      cycles(1);

      // T2: basic butterfly and latency
      send(16'h4000, 0, 16'h2000, 0, 16'h7FFF, 0, 1'b0, 1'b0);
      wait_out(lat);
      check("t2_latency", lat, 3);
      check("t2_Ya_re", Ya_re, 16'h5FFF);
      check("t2_Ya_im", Ya_im, 0);
      check("t2_Yb_re", Yb_re, 16'h2001);
      check("t2_Yb_im", Yb_im, 0);
      cycles(1);
      drain();
      check("t2_ovf", ovf, 0);

      // T3: conjugated twiddle (conj=1 expectation comes from the model's floor rule)
      send(0, 0, 16'h4000, 0, 0, 16'h7FFF, 1'b0, 1'b0);
      wait_out(lat);
      check("t3_Ya_im", Ya_im, 16'sh3FFF);
      check("t3_Yb_im", Yb_im, -16'sh3FFF);
      cycles(1);
      send(0, 0, 16'h4000, 0, 0, 16'h7FFF, 1'b1, 1'b0);
      drain();

      // T4: saturation, sticky ovf, clear, then scaled without saturation
      send(16'h7000, 0, 16'h7000, 0, 16'h7FFF, 0, 1'b0, 1'b0);
      wait_out(lat);
      check("t4_Ya_re_sat", Ya_re, 16'h7FFF);
      check("t4_Yb_re_sat", Yb_re, 16'h0001);
      cycles(1);
      drain();
      check("t4_ovf_set", ovf, 1);
      clr_ovf = 1'b1;
      cycles(1);
      clr_ovf = 1'b0;
      @(negedge clk);
      check("t4_ovf_clr", ovf, 0);
      cycles(1);
      send(16'h7000, 0, 16'h7000, 0, 16'h7FFF, 0, 1'b0, 1'b1);
      wait_out(lat);
      check("t4_Ya_re_scaled", Ya_re, 16'h7000);
      check("t4_Yb_re_scaled", Yb_re, 16'h0001);
      cycles(1);
      drain();
      check("t4_ovf_scaled", ovf, 0);

      // T5: 8 back-to-back samples, out_ready low for cycles 4..9
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(),
                    1'($urandom_range(1)), 1'($urandom_range(1)));
         end
         begin
            for (int cyc = 0; cyc < 12; cyc++) begin
               out_ready = !(cyc >= 4 && cyc <= 9);
               @(negedge clk);
               if (cyc >= 4 && cyc <= 9) begin
                  check("t5_stall_valid", out_valid, 1);
                  check("t5_stall_in_ready", in_ready, 0);
                  if (cyc == 4) begin
                     hold_a_re = Ya_re; hold_a_im = Ya_im;
                     hold_b_re = Yb_re; hold_b_im = Yb_im;
                  end else begin
                     check("t5_hold_Ya_re", Ya_re, hold_a_re);
                     check("t5_hold_Ya_im", Ya_im, hold_a_im);
                     check("t5_hold_Yb_re", Yb_re, hold_b_re);
                     check("t5_hold_Yb_im", Yb_im, hold_b_im);
                  end
               end
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Randomized stream with random gaps and random backpressure
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(3) == 0) cycles(1);
               send(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(),
                    1'($urandom_range(1)), 1'($urandom_range(1)));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               out_ready = ($urandom_range(9) < 7);
               cycles(1);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // T6: reset with three samples in flight (output stalled so none leave)
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         send(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b0);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t6_no_out_valid", out_valid, 0);
         cycles(1);
      end
      check("t6_flushed", sb.size(), 0);
      send(16'h1234, -100, 16'h0800, 16'h0400, 16'h5A82, -16'sh5A82, 1'b1, 1'b0);
      wait_out(lat);
      check("t6_latency", lat, 3);
      cycles(1);
      drain();

      check("final_sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
